// File: rtl/axis_frame_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_frame_rr_arbiter
//
// Frame-aware round-robin arbiter that merges S_COUNT AXI4-Stream sources
// onto one sink. A port keeps its grant until its tlast beat is accepted, so
// frames from different sources never interleave. The winning source index
// travels with each beat on m_axis_tid. The output goes through a 2-entry
// skid stage (output register plus one spare entry). Input ready depends only
// on the spare entry, so m_axis_tready has no combinational path back to
// s_axis_tready, and throughput stays at one beat per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   enable            allow new grants (a frame in progress always completes)
//   s_axis_*          S_COUNT packed source streams, port i at slice i
//   m_axis_*          merged output stream, tid = source index of the beat
//   grant_valid       a frame is currently granted
//   grant_index       currently or most recently granted port
// ---------------------------------------------------------------------------
module axis_frame_rr_arbiter #(
   parameter int S_COUNT     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
   parameter int USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1,
   parameter int SEL_WIDTH   = $clog2(S_COUNT)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [S_COUNT-1:0]            s_axis_tvalid,
   output logic [S_COUNT-1:0]            s_axis_tready,
   input  logic [S_COUNT-1:0]            s_axis_tlast,
   input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [SEL_WIDTH-1:0]          m_axis_tid,
   output logic [USER_WIDTH-1:0]         m_axis_tuser,
   output logic                          grant_valid,
   output logic [SEL_WIDTH-1:0]          grant_index
);

   // One beat as stored in the skid stage: {data, keep, user, tid, last}
   localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + SEL_WIDTH + 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                  state, state_next;
   logic [SEL_WIDTH-1:0]    grant_index_reg, grant_index_next;

   logic                    arb_found;
   logic [SEL_WIDTH-1:0]    arb_winner;

   logic [DATA_WIDTH-1:0]   sel_tdata;
   logic [KEEP_WIDTH-1:0]   sel_tkeep;
   logic [USER_WIDTH-1:0]   sel_tuser;
   logic                    sel_tvalid;
   logic                    sel_tlast;

   logic                    in_ready;
   logic                    accept;
   logic [BEAT_W-1:0]       beat_in;

   logic                    out_valid;
   logic [BEAT_W-1:0]       out_beat;
   logic                    skid_valid;
   logic [BEAT_W-1:0]       skid_beat;

   // Round-robin search: the first requester found walking upward from the
   // port after the last grant, wrapping around. The last granted port is
   // therefore checked last, which is what gives every port its turn.
   always_comb begin
      logic [SEL_WIDTH-1:0] idx;
      arb_found  = 1'b0;
      arb_winner = grant_index_reg;
      idx        = '0;
      for (int k = 1; k <= S_COUNT; k++) begin
         idx = SEL_WIDTH'((int'(grant_index_reg) + k) % S_COUNT);
         if (!arb_found && s_axis_tvalid[idx]) begin
            arb_found  = 1'b1;
            arb_winner = idx;
         end
      end
   end

   // Mux the granted source onto a single internal beat. A compare loop is
   // used rather than a variable part-select so non-power-of-two S_COUNT
   // values never index past the packed vectors.
   always_comb begin
      sel_tdata  = '0;
      sel_tkeep  = '0;
      sel_tuser  = '0;
      sel_tvalid = 1'b0;
      sel_tlast  = 1'b0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (SEL_WIDTH'(i) == grant_index_reg) begin
            sel_tdata  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
            sel_tkeep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            sel_tuser  = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            sel_tvalid = s_axis_tvalid[i];
            sel_tlast  = s_axis_tlast[i];
         end
      end
   end

   // Only the granted port sees ready, and only while the spare skid entry is
   // free. Because this looks at registered state alone, the downstream ready
   // never reaches the sources combinationally.
   always_comb begin
      s_axis_tready = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (state == BUSY && SEL_WIDTH'(i) == grant_index_reg) begin
            s_axis_tready[i] = !skid_valid;
         end
      end
   end

   assign in_ready = (state == BUSY) && !skid_valid;
   assign accept   = in_ready && sel_tvalid;
   assign beat_in  = {sel_tdata, sel_tkeep, sel_tuser, grant_index_reg, sel_tlast};

   // Next-state logic. A grant is only issued from IDLE, and enable only
   // gates that decision, so a running frame always finishes. Releasing on
   // the tlast edge and re-arbitrating from IDLE leaves exactly one dead
   // input cycle between frames.
   always_comb begin
      state_next       = state;
      grant_index_next = grant_index_reg;
      case (state)
         IDLE: begin
            if (enable && arb_found) begin
               state_next       = BUSY;
               grant_index_next = arb_winner;
            end
         end
         BUSY: begin
            if (accept && sel_tlast) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Arbiter state register. The pointer resets to the last port so the
   // first search after reset starts at port 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         grant_index_reg <= SEL_WIDTH'(S_COUNT - 1);
      end else begin
         state           <= state_next;
         grant_index_reg <= grant_index_next;
      end
   end

   // Skid stage. When the output register is free or being drained, it is
   // refilled from the spare entry first (older beat), otherwise from the
   // input. When the output is stalled, a newly accepted beat parks in the
   // spare entry, which in turn drops input ready until it moves forward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_beat   <= '0;
         skid_valid <= 1'b0;
         skid_beat  <= '0;
      end else begin
         if (!out_valid || m_axis_tready) begin
            if (skid_valid) begin
               out_beat   <= skid_beat;
               out_valid  <= 1'b1;
               skid_valid <= 1'b0;
            end else if (accept) begin
               out_beat  <= beat_in;
               out_valid <= 1'b1;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_beat  <= beat_in;
            skid_valid <= 1'b1;
         end
      end
   end

   // Unpack the output register; disabled sidebands are tied off here.
   logic [KEEP_WIDTH-1:0] out_keep;
   logic [USER_WIDTH-1:0] out_user;

   assign {m_axis_tdata, out_keep, out_user, m_axis_tid, m_axis_tlast} = out_beat;
   assign m_axis_tkeep  = (KEEP_ENABLE != 0) ? out_keep : {KEEP_WIDTH{1'b1}};
   assign m_axis_tuser  = (USER_ENABLE != 0) ? out_user : {USER_WIDTH{1'b0}};
   assign m_axis_tvalid = out_valid;

   assign grant_valid = (state == BUSY);
   assign grant_index = grant_index_reg;

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_frame_rr_arbiter
//
// Bench for axis_frame_rr_arbiter (S_COUNT=4, DATA_WIDTH=8). Each source port
// has a small beat memory that is presented one beat at a time. Expected
// output beats go into a queue as frames are loaded, and a monitor pops and
// compares them whenever the DUT hands a beat downstream. Arbitration order
// is exercised from a table of {request mask, expected grant} records.
// ---------------------------------------------------------------------------
module tb_axis_frame_rr_arbiter;

   localparam int S_COUNT = 4;
   localparam int DW      = 8;
   localparam int KW      = 1;
   localparam int UW      = 1;
   localparam int SW      = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  enable = 1'b0;
   logic [S_COUNT*DW-1:0] s_axis_tdata;
   logic [S_COUNT*KW-1:0] s_axis_tkeep;
   logic [S_COUNT-1:0]    s_axis_tvalid;
   logic [S_COUNT-1:0]    s_axis_tready;
   logic [S_COUNT-1:0]    s_axis_tlast;
   logic [S_COUNT*UW-1:0] s_axis_tuser;
   logic [DW-1:0]         m_axis_tdata;
   logic [KW-1:0]         m_axis_tkeep;
   logic                  m_axis_tvalid;
   logic                  m_axis_tready;
   logic                  m_axis_tlast;
   logic [SW-1:0]         m_axis_tid;
   logic [UW-1:0]         m_axis_tuser;
   logic                  grant_valid;
   logic [SW-1:0]         grant_index;

   axis_frame_rr_arbiter #(
      .S_COUNT    (S_COUNT),
      .DATA_WIDTH (DW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tuser  (s_axis_tuser),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tid    (m_axis_tid),
      .m_axis_tuser  (m_axis_tuser),
      .grant_valid   (grant_valid),
      .grant_index   (grant_index)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   typedef struct {
      logic [S_COUNT-1:0] mask;
      logic [SW-1:0]      exp_grant;
   } arb_vec_t;

   arb_vec_t     vecs [9];
   int           checks = 0;
   int           errors = 0;
   logic [11:0]  sb [$];
   logic [8:0]   mem [S_COUNT][64];
   int           wr_ptr [S_COUNT];
   int           rd_ptr [S_COUNT];
   logic [11:0]  exp_beat;

   // One comparison: counts it and reports a mismatch on a single line
   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Present the head beat of every source memory on the packed inputs
   task automatic apply_stimulus();
      logic [8:0] beat;
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tlast  = '0;
      s_axis_tuser  = '0;
      s_axis_tkeep  = '1;
      for (int i = 0; i < S_COUNT; i++) begin
         if (rd_ptr[i] < wr_ptr[i]) begin
            beat                   = mem[i][rd_ptr[i]];
            s_axis_tvalid[i]       = 1'b1;
            s_axis_tdata[i*DW +: DW] = beat[7:0];
            s_axis_tlast[i]        = beat[8];
            s_axis_tuser[i]        = beat[0];
         end
      end
   endtask

   // Queue a frame on a port; tuser carries data bit 0. When push is set the
   // expected output beats go to the scoreboard in load order.
   task automatic load_frame(input int port, input int n, input logic [7:0] base,
                             input bit push);
      logic [7:0] d;
      logic       last;
      for (int j = 0; j < n; j++) begin
         d    = base + 8'(j);
         last = (j == n - 1);
         mem[port][wr_ptr[port]] = {last, d};
         wr_ptr[port]++;
         if (push) sb.push_back({d[0], SW'(port), last, d});
      end
   endtask

   task automatic flush_sources();
      for (int i = 0; i < S_COUNT; i++) begin
         rd_ptr[i] = 0;
         wr_ptr[i] = 0;
      end
   endtask

   // One clock: sample handshakes away from the edge, then advance sources
   task automatic step();
      logic [S_COUNT-1:0] fire;
      @(negedge clk);
      fire = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < S_COUNT; i++) begin
         if (fire[i]) rd_ptr[i]++;
      end
      apply_stimulus();
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check_output(name, sb.size(), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      flush_sources();
      sb.delete();
      apply_stimulus();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Scoreboard monitor: every beat handed downstream must match the queue
   always @(negedge clk) begin
      if (rst_n && m_axis_tvalid && m_axis_tready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_beat: got %0h, expected no beat",
                     {m_axis_tuser, m_axis_tid, m_axis_tlast, m_axis_tdata});
         end else begin
            exp_beat = sb.pop_front();
            check_output("beat", {m_axis_tuser, m_axis_tid, m_axis_tlast, m_axis_tdata},
                         exp_beat);
         end
      end
   end

   // Hard stop in case something above never returns
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [1:0]  t1_pat [9];
      logic        t3_pat [16];
      logic [3:0]  other_ready;
      logic        saw_stall;
      int          n;

      m_axis_tready = 1'b1;
      flush_sources();
      apply_stimulus();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_grant_index", grant_index, 3);
      check_output("rst_grant_valid", grant_valid, 0);
      check_output("rst_m_tvalid", m_axis_tvalid, 0);
      check_output("rst_m_tdata", m_axis_tdata, 0);
      check_output("rst_m_tid", m_axis_tid, 0);
      check_output("rst_m_tlast", m_axis_tlast, 0);
      check_output("rst_s_tready", s_axis_tready, 0);
      rst_n  = 1'b1;
      enable = 1'b1;

      // Ports 1 and 3 contend: port 1 frame first, one idle cycle, port 3
      t1_pat = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
      load_frame(1, 3, 8'h10, 1'b1);
      load_frame(3, 3, 8'h30, 1'b1);
      apply_stimulus();
      for (int k = 0; k < 9; k++) begin
         step();
         check_output($sformatf("t1_m_tvalid_%0d", k + 1), m_axis_tvalid, t1_pat[k]);
      end
      drain("t1_drain", 10);

      // All ports stream 1-beat frames: tid 0,1,2,3,0,... with a dead cycle each
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < S_COUNT; p++) begin
            load_frame(p, 1, 8'h40 + 8'(4 * r + p), 1'b1);
         end
      end
      apply_stimulus();
      for (int k = 1; k <= 16; k++) begin
         step();
         check_output($sformatf("t2_m_tvalid_%0d", k), m_axis_tvalid, (k % 2 == 0));
      end
      drain("t2_drain", 10);

      // Table-driven arbitration order starting from a fresh pointer
      do_reset();
      vecs[0] = '{4'b1010, 2'd1};
      vecs[1] = '{4'b1010, 2'd3};
      vecs[2] = '{4'b0011, 2'd0};
      vecs[3] = '{4'b1001, 2'd3};
      vecs[4] = '{4'b0100, 2'd2};
      vecs[5] = '{4'b0010, 2'd1};
      vecs[6] = '{4'b1111, 2'd2};
      vecs[7] = '{4'b0001, 2'd0};
      vecs[8] = '{4'b1000, 2'd3};
      for (int v = 0; v < 9; v++) begin
         logic [7:0] d;
         for (int p = 0; p < S_COUNT; p++) begin
            if (vecs[v].mask[p]) load_frame(p, 1, 8'hA0 + 8'(p), 1'b0);
         end
         d = 8'hA0 + 8'(vecs[v].exp_grant);
         sb.push_back({d[0], vecs[v].exp_grant, 1'b1, d});
         apply_stimulus();
         step();
         check_output($sformatf("arb_vec_%0d", v), {grant_valid, grant_index},
                      {1'b1, vecs[v].exp_grant});
         step();
         flush_sources();
         apply_stimulus();
      end
      drain("arb_drain", 10);

      // Port 2 five-beat frame against a stalling sink
      t3_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      other_ready = '0;
      saw_stall   = 1'b0;
      load_frame(2, 5, 8'h60, 1'b1);
      apply_stimulus();
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         m_axis_tready = (n < 16) ? t3_pat[n] : 1'b1;
         step();
         other_ready = other_ready | (s_axis_tready & 4'b1011);
         if (grant_valid && !s_axis_tready[2]) saw_stall = 1'b1;
         n++;
      end
      m_axis_tready = 1'b1;
      check_output("t3_drain", sb.size(), 0);
      check_output("t3_other_ready", other_ready, 0);
      check_output("t3_backpressure_seen", saw_stall, 1);
      check_output("t3_released", grant_valid, 0);

      // enable gating: no grant while low, grant once raised, frame completes
      do_reset();
      enable = 1'b0;
      load_frame(0, 2, 8'h70, 1'b1);
      apply_stimulus();
      repeat (3) step();
      check_output("t4_no_grant", grant_valid, 0);
      check_output("t4_no_output", m_axis_tvalid, 0);
      enable = 1'b1;
      step();
      check_output("t4_grant", {grant_valid, grant_index}, {1'b1, 2'd0});
      enable = 1'b0;
      load_frame(1, 1, 8'h80, 1'b0);
      apply_stimulus();
      repeat (6) step();
      check_output("t4_frame_done", sb.size(), 0);
      check_output("t4_no_new_grant", grant_valid, 0);
      check_output("t4_port1_untouched", rd_ptr[1], 0);
      flush_sources();
      apply_stimulus();
      enable = 1'b1;

      // Asynchronous reset in the middle of a frame
      do_reset();
      load_frame(0, 4, 8'h90, 1'b0);
      sb.push_back({1'b0, 2'd0, 1'b0, 8'h90});
      apply_stimulus();
      repeat (3) step();
      check_output("t5_mid_frame_valid", m_axis_tvalid, 1);
      rst_n = 1'b0;
      #1;
      check_output("t5_async_m_tvalid", m_axis_tvalid, 0);
      check_output("t5_async_s_tready", s_axis_tready, 0);
      check_output("t5_async_grant_valid", grant_valid, 0);
      flush_sources();
      apply_stimulus();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_output("t5_first_beat_seen", sb.size(), 0);
      load_frame(3, 1, 8'hB3, 1'b1);
      apply_stimulus();
      step();
      check_output("t5_regrant", {grant_valid, grant_index}, {1'b1, 2'd3});
      drain("t5_drain", 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
